// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
// MULDIV_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
package muldiv_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8,
    OP_MSUBU = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
  localparam int CNT_W   = 4;

`ifdef MULDIV_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  function automatic logic is_mac_op(input logic [3:0] op);
    return (op == OP_MADD) || (op == OP_MADDU) ||
           (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) ||
           (MADD_EN && is_mac_op(op));
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_arith.sv
// Combinational 64-bit multiply, divide and accumulate datapath.
// Accumulate ops exist only when MULDIV_MADD_EN is defined.
module muldiv_arith
  import muldiv_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        res_wr
);

  logic        sgn;
  logic [63:0] sa, sb, prod;
  logic        a_neg, b_neg;
  logic [31:0] ua, ub, ub_nz;
  logic [31:0] uq, ur, q, r;

  assign sgn = (op == OP_MULT) || (op == OP_DIV) ||
               (op == OP_MADD) || (op == OP_MSUB);

  // sign- or zero-extend to 64 bits; low 64 bits of the product are exact
  assign sa   = {{32{sgn & a[31]}}, a};
  assign sb   = {{32{sgn & b[31]}}, b};
  assign prod = sa * sb;

  // divide on magnitudes, then restore signs (truncate toward zero)
  assign a_neg = sgn & a[31];
  assign b_neg = sgn & b[31];
  assign ua    = a_neg ? -a : a;
  assign ub    = b_neg ? -b : b;
  assign ub_nz = (ub == 32'd0) ? 32'd1 : ub;
  assign uq    = ua / ub_nz;
  assign ur    = ua % ub_nz;
  assign q     = (a_neg ^ b_neg) ? -uq : uq;
  assign r     = a_neg ? -ur : ur;

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    res_wr = 1'b0;
    case (op)
      OP_MULT, OP_MULTU: begin
        {res_hi, res_lo} = prod;
        res_wr = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        if (b != 32'd0) begin
          res_hi = r;
          res_lo = q;
          res_wr = 1'b1;
        end
      end
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MADDU: begin
        {res_hi, res_lo} = {hi, lo} + prod;
        res_wr = 1'b1;
      end
      OP_MSUB, OP_MSUBU: begin
        {res_hi, res_lo} = {hi, lo} - prod;
        res_wr = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer with fixed-latency result commit.
// MULDIV_MADD_EN adds MADD/MADDU/MSUB/MSUBU via the MUL path.
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall_hilo,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      rhi_q, rhi_d, rlo_q, rlo_d;
  logic             wr_q, wr_d;
  logic             done_q, done_d;
  logic [31:0]      ar_hi, ar_lo;
  logic             ar_wr;

  muldiv_arith u_arith (
    .op     (op),
    .a      (a),
    .b      (b),
    .hi     (hi_q),
    .lo     (lo_q),
    .res_hi (ar_hi),
    .res_lo (ar_lo),
    .res_wr (ar_wr)
  );

  assign busy       = (state_q != S_IDLE);
  assign stall_hilo = busy |
                      (start & (is_mul_op(op) | is_div_op(op)));
  assign done       = done_q;
  assign hi         = hi_q;
  assign lo         = lo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rhi_d   = rhi_q;
    rlo_d   = rlo_q;
    wr_d    = wr_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (1'b1)
            is_mul_op(op): begin
              state_d = S_MUL;
              cnt_d   = CNT_W'(MUL_LAT - 1);
              rhi_d   = ar_hi;
              rlo_d   = ar_lo;
              wr_d    = ar_wr;
            end
            is_div_op(op): begin
              state_d = S_DIV;
              cnt_d   = CNT_W'(DIV_LAT - 1);
              rhi_d   = ar_hi;
              rlo_d   = ar_lo;
              wr_d    = ar_wr;
            end
            (op == OP_MTHI): hi_d = a;
            (op == OP_MTLO): lo_d = a;
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (wr_q) begin
            hi_d = rhi_q;
            lo_d = rlo_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rhi_q   <= '0;
      rlo_q   <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rhi_q   <= rhi_d;
      rlo_q   <= rlo_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed table, corner
// sequences and randomized ops against a plain-arithmetic model.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, stall_hilo, done;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mhi, mlo;

  muldiv_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .stall_hilo (stall_hilo),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [31:0] ihi, ilo;
    int          lat;
    logic [31:0] ehi, elo;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // reference: updates mhi/mlo, returns expected busy cycles
  function automatic int model(input logic [3:0] o,
                               input logic [31:0] x,
                               input logic [31:0] y);
    longint          sx, sy, q, r;
    longint unsigned ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      4'd0: begin {mhi, mlo} = sx * sy; return MUL_LAT; end
      4'd1: begin {mhi, mlo} = ux * uy; return MUL_LAT; end
      4'd2: begin
        if (y != 0) begin
          q = sx / sy; r = sx % sy;
          mlo = q[31:0]; mhi = r[31:0];
        end
        return DIV_LAT;
      end
      4'd3: begin
        if (y != 0) begin
          p = ux / uy; mlo = p[31:0];
          p = ux % uy; mhi = p[31:0];
        end
        return DIV_LAT;
      end
      4'd4: begin mhi = x; return 0; end
      4'd5: begin mlo = x; return 0; end
      4'd6, 4'd7, 4'd8, 4'd9: begin
        if (!MADD_EN) return 0;
        p = (o == 4'd6 || o == 4'd8) ? sx * sy : ux * uy;
        if (o <= 4'd7) {mhi, mlo} = {mhi, mlo} + p;
        else           {mhi, mlo} = {mhi, mlo} - p;
        return MUL_LAT;
      end
      default: return 0;
    endcase
  endfunction

  // called at a negedge; returns at the done cycle (or after issue)
  task automatic exec(input logic [3:0] o, input logic [31:0] x,
                      input logic [31:0] y, input int lat,
                      input logic [31:0] eh, input logic [31:0] el,
                      input string nm);
    int n;
    start = 1'b1; op = o; a = x; b = y;
    #1;
    chk({nm, ".stall"}, 32'(stall_hilo), 32'(lat > 0));
    @(negedge clk);
    start = 1'b0;
    if (lat == 0) begin
      chk({nm, ".busy"}, 32'(busy), 32'd0);
      chk({nm, ".done"}, 32'(done), 32'd0);
    end else begin
      chk({nm, ".done_lo"}, 32'(done), 32'd0);
      n = 0;
      while (busy && n < 40) begin
        n++;
        @(negedge clk);
      end
      chk({nm, ".lat"}, 32'(n), 32'(lat));
      chk({nm, ".done"}, 32'(done), 32'd1);
    end
    chk({nm, ".hi"}, hi, eh);
    chk({nm, ".lo"}, lo, el);
  endtask

  initial begin
    int n, nd, lat;
    logic [3:0] rop;
    logic [31:0] ra, rb;

    vecs[0] = '{"mult", 4'd0, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0,
                5, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{"multu", 4'd1, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0,
                5, 32'h00000002, 32'hFFFFFFFA};
    vecs[2] = '{"div", 4'd2, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0,
                10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{"divu0", 4'd3, 32'h1234, 32'd0, 32'h11, 32'h22,
                10, 32'h11, 32'h22};
    vecs[4] = '{"divovf", 4'd2, 32'h80000000, 32'hFFFFFFFF,
                32'h5, 32'h6, 10, 32'h0, 32'h80000000};
    vecs[5] = '{"divu", 4'd3, 32'hFFFFFFFF, 32'h10, 32'h0, 32'h0,
                10, 32'hF, 32'h0FFFFFFF};
    vecs[6] = '{"madd", 4'd6, 32'd3, 32'd4, 32'h0, 32'd5,
                MADD_EN ? 5 : 0, 32'h0, MADD_EN ? 32'd17 : 32'd5};
    vecs[7] = '{"msub", 4'd8, 32'd3, 32'd4, 32'h0, 32'd5,
                MADD_EN ? 5 : 0,
                MADD_EN ? 32'hFFFFFFFF : 32'h0,
                MADD_EN ? 32'hFFFFFFF9 : 32'd5};
    vecs[8] = '{"illegal", 4'hF, 32'hDEAD, 32'hBEEF, 32'h1, 32'h2,
                0, 32'h1, 32'h2};

    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.hi", hi, 32'd0);
    chk("rst.lo", lo, 32'd0);
    chk("rst.stall", 32'(stall_hilo), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      exec(4'd4, vecs[i].ihi, 32'd0, 0, vecs[i].ihi, lo,
           {vecs[i].name, ".mthi"});
      exec(4'd5, vecs[i].ilo, 32'd0, 0, vecs[i].ihi, vecs[i].ilo,
           {vecs[i].name, ".mtlo"});
      exec(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat,
           vecs[i].ehi, vecs[i].elo, vecs[i].name);
      @(negedge clk);
      chk({vecs[i].name, ".done_end"}, 32'(done), 32'd0);
    end

    // start while busy is ignored
    start = 1'b1; op = 4'd0; a = 32'd7; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (busy && n < 40) begin
      if (n == 2) begin
        start = 1'b1; op = 4'd2; a = 32'd99; b = 32'd9;
      end else begin
        start = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("ign.lat", 32'(n - 1), 32'd5);
    chk("ign.done", 32'(done), 32'd1);
    chk("ign.hi", hi, 32'd0);
    chk("ign.lo", lo, 32'd42);
    @(negedge clk);
    chk("ign.busy_after", 32'(busy), 32'd0);

    // reset on the 4th busy cycle of a DIV
    start = 1'b1; op = 4'd2; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.hi", hi, 32'd0);
    chk("arst.lo", lo, 32'd0);
    chk("arst.done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("arst.no_done", 32'(nd), 32'd0);
    chk("arst.lo_kept", lo, 32'd0);
    exec(4'd5, 32'd5, 32'd0, 0, 32'd0, 32'd5, "arst.mtlo");

    // random, back-to-back issue including at the done cycle
    mhi = hi; mlo = lo;
    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 9) == 0) rop = 4'hF;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = 32'hFFFFFFFF;
        default: ;
      endcase
      lat = model(rop, ra, rb);
      exec(rop, ra, rb, lat, mhi, mlo, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
